// File: rtl/fp_add_sched_pkg.sv
// Shared definitions for the two-requester float32 add scheduler: FSM states,
// float32 field layout and a mantissa-unpacking helper.
package fp_add_sched_pkg;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_e;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'd255;

  // 24-bit significand with the hidden bit restored (0 for zero/denormal exponent)
  function automatic logic [MAN_W:0] full_man(input logic [31:0] f);
    return {(f[EXP_MSB:EXP_LSB] != '0), f[MAN_MSB:0]};
  endfunction

endpackage

// File: rtl/fp_align_norm.sv
// Combinational float32 datapath: align the smaller operand, add or subtract
// magnitudes, left-normalise, and apply the zero-operand / zero-difference overrides.
module fp_align_norm
  import fp_add_sched_pkg::*;
(
  input  logic             comp,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [EXP_W-1:0] big_exp,
  input  logic [EXP_W-1:0] small_exp,
  input  logic [MAN_W:0]   big_man,
  input  logic [MAN_W:0]   small_man,
  output logic [31:0]      result
);

  logic [EXP_W-1:0] shamt;
  logic [MAN_W:0]   aligned;
  logic [MAN_W:0]   mag;
  logic [MAN_W:0]   norm;
  logic [4:0]       lz;
  logic             found;
  logic             eff_sub;
  logic             sign_r;
  logic [EXP_W-1:0] exp_r;

  always_comb begin
    shamt   = big_exp - small_exp;
    aligned = (shamt >= 8'd24) ? '0 : (small_man >> shamt);
    eff_sub = sign_a ^ sign_b;
    sign_r  = comp ? sign_a : sign_b;
    // Add overflow past 24 bits is outside the supported range, so it simply truncates.
    mag     = eff_sub ? (big_man - aligned) : (big_man + aligned);
    lz      = '0;
    found   = 1'b0;
    for (int i = MAN_W; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lz    = 5'(MAN_W - i);
        found = 1'b1;
      end
    end
    norm   = mag << lz;
    exp_r  = big_exp - {3'b000, lz};
    result = {sign_r, exp_r, norm[MAN_W-1:0]};
    if (small_exp == '0)
      result = {sign_r, big_exp, big_man[MAN_W-1:0]};
    else if (eff_sub && (mag == '0))
      result = '0;
  end

endmodule

// File: rtl/fp_add_sched.sv
// Two-requester float32 adder: arbitrates one operand pair at a time, runs it
// through ALIGN/ADD, then holds the sum in DONE until the consumer takes it.
module fp_add_sched
  import fp_add_sched_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_id,
  output logic        busy
);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic             comp_q, comp_d;
  logic [EXP_W-1:0] bexp_q, bexp_d, sexp_q, sexp_d;
  logic [MAN_W:0]   bman_q, bman_d, sman_q, sman_d;
  logic [31:0]      res_q, res_d;
  logic [31:0]      dp_res;
  logic             gnt1;

  // Requester 1 wins when alone, or when both ask and the round-robin pointer favours it.
  assign gnt1 = req1_valid & (~req0_valid | ((ROUND_ROBIN != 0) & rr_q));

  fp_align_norm u_dp (
    .comp      (comp_q),
    .sign_a    (a_q[SIGN_BIT]),
    .sign_b    (b_q[SIGN_BIT]),
    .big_exp   (bexp_q),
    .small_exp (sexp_q),
    .big_man   (bman_q),
    .small_man (sman_q),
    .result    (dp_res)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    comp_d     = comp_q;
    bexp_d     = bexp_q;
    sexp_d     = sexp_q;
    bman_d     = bman_q;
    sman_d     = sman_q;
    res_d      = res_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~gnt1;
          req1_ready = gnt1;
          a_d        = gnt1 ? req1_a : req0_a;
          b_d        = gnt1 ? req1_b : req0_b;
          id_d       = gnt1;
          rr_d       = ~gnt1;
          state_d    = ALIGN;
        end
      end
      ALIGN: begin
        comp_d  = (a_q[EXP_MSB:0] >= b_q[EXP_MSB:0]);
        bexp_d  = comp_d ? a_q[EXP_MSB:EXP_LSB] : b_q[EXP_MSB:EXP_LSB];
        sexp_d  = comp_d ? b_q[EXP_MSB:EXP_LSB] : a_q[EXP_MSB:EXP_LSB];
        bman_d  = comp_d ? full_man(a_q) : full_man(b_q);
        sman_d  = comp_d ? full_man(b_q) : full_man(a_q);
        state_d = ADD;
      end
      ADD: begin
        res_d   = dp_res;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      comp_q  <= 1'b0;
      bexp_q  <= '0;
      sexp_q  <= '0;
      bman_q  <= '0;
      sman_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      comp_q  <= comp_d;
      bexp_q  <= bexp_d;
      sexp_q  <= sexp_d;
      bman_q  <= bman_d;
      sman_q  <= sman_d;
      res_q   <= res_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_id     = id_q;
  assign busy       = (state_q != IDLE);

endmodule
